spi_peripheral: RTL and testbench

//  Synthesizable SPI mode-0 responder: the subnode end of the link driven by spi_controller.

---
 rtl/spi_peripheral.sv | 133 +++++++++++++
 tb/tb_spi_peripheral.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 responder, oversampled in the clk domain, MSB-first, streaming replies.
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   SPI_SCLK/CS/MOSI/MISO    SPI link (SCLK idle low, CS active low)
//   data_to_send, tx_load    reply byte and its write strobe into the holding register
//   tx_ready                 holding register empty
//   data_received, rx_valid  last complete byte and its one-cycle strobe
//   busy                     frame in progress
//   frame_abort              one-cycle strobe when CS rises mid-byte
module spi_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEFAULT_TX  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SPI_SCLK,
  input  logic       SPI_CS,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  input  logic [7:0] data_to_send,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] data_received,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_abort
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d, armed_q, armed_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d, hold_q, hold_d, data_received_q, data_received_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic hold_full_q, hold_full_d, rx_valid_q, rx_valid_d, frame_abort_q, frame_abort_d;
  logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall, byte_start;
  logic [7:0] reload;
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  // A CS fall only counts once CS has been seen high on real samples after reset,
  // so a frame already running when reset hit is ignored until CS cycles.
  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
  assign byte_start = (state_q == IDLE) ? cs_fall
                                        : (~cs_rise & sclk_fall & (bit_cnt_q == 3'd0));
  assign reload    = hold_full_q ? hold_q : DEFAULT_TX;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (state_q == IDLE) ? (cs_fall ? ACTIVE : IDLE) : (cs_rise ? IDLE : ACTIVE);
  assign busy          = state_q == ACTIVE;
  assign SPI_MISO      = tx_shift_q[7];
  assign tx_ready      = ~hold_full_q;
  assign data_received = data_received_q;
  assign rx_valid      = rx_valid_q;
  assign frame_abort   = frame_abort_q;
  always_comb begin
    sclk_sync_d     = {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
    cs_sync_d       = {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
    mosi_sync_d     = {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
    fill_d          = {fill_q[SYNC_STAGES-2:0], 1'b1};
    sclk_prev_d     = sclk_s;
    cs_prev_d       = cs_s;
    armed_d         = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
    // A load in the same cycle as a byte start wins: the old byte was already taken by reload.
    hold_d          = tx_load ? data_to_send : hold_q;
    hold_full_d     = tx_load | (hold_full_q & ~byte_start);
    tx_shift_d      = tx_shift_q;
    bit_cnt_d       = bit_cnt_q;
    rx_shift_d      = rx_shift_q;
    data_received_d = data_received_q;
    rx_valid_d      = 1'b0;
    frame_abort_d   = 1'b0;
    if (byte_start) begin
      tx_shift_d = reload;
      bit_cnt_d  = 3'd0;
    end else if (state_q == ACTIVE) begin
      if (cs_rise) begin
        tx_shift_d    = 8'd0;
        bit_cnt_d     = 3'd0;
        frame_abort_d = bit_cnt_q != 3'd0;
      end else if (sclk_rise) begin
        rx_shift_d = {rx_shift_q[5:0], mosi_s};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          data_received_d = {rx_shift_q, mosi_s};
          rx_valid_d      = 1'b1;
        end
      end else if (sclk_fall) begin
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_sync_q     <= '0;
      cs_sync_q       <= '1;
      mosi_sync_q     <= '0;
      fill_q          <= '0;
      sclk_prev_q     <= 1'b0;
      cs_prev_q       <= 1'b1;
      armed_q         <= 1'b0;
      hold_q          <= 8'd0;
      hold_full_q     <= 1'b0;
      tx_shift_q      <= 8'd0;
      bit_cnt_q       <= 3'd0;
      rx_shift_q      <= 7'd0;
      data_received_q <= 8'd0;
      rx_valid_q      <= 1'b0;
      frame_abort_q   <= 1'b0;
    end else begin
      sclk_sync_q     <= sclk_sync_d;
      cs_sync_q       <= cs_sync_d;
      mosi_sync_q     <= mosi_sync_d;
      fill_q          <= fill_d;
      sclk_prev_q     <= sclk_prev_d;
      cs_prev_q       <= cs_prev_d;
      armed_q         <= armed_d;
      hold_q          <= hold_d;
      hold_full_q     <= hold_full_d;
      tx_shift_q      <= tx_shift_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_shift_q      <= rx_shift_d;
      data_received_q <= data_received_d;
      rx_valid_q      <= rx_valid_d;
      frame_abort_q   <= frame_abort_d;
    end
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: drives the peripheral as a mode-0 controller and checks against a byte-level model.
module tb_spi_peripheral;
  localparam int H = 8;
  logic clk = 0, rst = 1, SPI_SCLK = 0, SPI_CS = 1, SPI_MOSI = 0, tx_load = 0;
  logic [7:0] data_to_send = 8'd0;
  logic SPI_MISO, tx_ready, rx_valid, busy, frame_abort;
  logic [7:0] data_received;
  int n_tests = 0, n_fail = 0, rv_cnt = 0, ab_cnt = 0;
  logic [7:0] model_held = 8'd0, model_rx = 8'd0;
  bit model_full = 0;
  logic [7:0] fr_tx [3];
  logic [7:0] fr_lv [3];
  bit fr_ld [3];
  spi_peripheral dut (
    .clk(clk), .rst(rst), .SPI_SCLK(SPI_SCLK), .SPI_CS(SPI_CS), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .data_to_send(data_to_send), .tx_load(tx_load), .tx_ready(tx_ready),
    .data_received(data_received), .rx_valid(rx_valid), .busy(busy), .frame_abort(frame_abort)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid) rv_cnt++;
    if (frame_abort) ab_cnt++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic load_byte(input logic [7:0] v);
    data_to_send = v;
    tx_load = 1;
    tick(1);
    tx_load = 0;
    model_held = v;
    model_full = 1;
    check("tx_ready_full", tx_ready, 0);
  endtask
  // One byte as a mode-0 controller; optional load right after the byte's rx_valid, before its last fall.
  task automatic spi_byte(input logic [7:0] tx, input bit ld, input logic [7:0] lv, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      SPI_MOSI = tx[i];
      tick(H);
      rx[i] = SPI_MISO;
      SPI_SCLK = 1;
      if (i == 0) begin
        tick(5);
        if (ld) begin
          data_to_send = lv;
          tx_load = 1;
          model_held = lv;
          model_full = 1;
        end
        tick(1);
        tx_load = 0;
        tick(H - 6);
      end else tick(H);
      SPI_SCLK = 0;
    end
  endtask
  task automatic run_frame(input int n);
    int rv0, ab0;
    logic [7:0] exp_reply, rx;
    rv0 = rv_cnt;
    ab0 = ab_cnt;
    exp_reply = model_full ? model_held : 8'hFF;
    model_full = 0;
    SPI_CS = 0;
    tick(H);
    check("busy_active", busy, 1);
    check("tx_ready_start", tx_ready, 1);
    for (int j = 0; j < n; j++) begin
      spi_byte(fr_tx[j], fr_ld[j], fr_lv[j], rx);
      check("reply", rx, exp_reply);
      check("rx_data", data_received, fr_tx[j]);
      model_rx = fr_tx[j];
      exp_reply = model_full ? model_held : 8'hFF;
      model_full = 0;
    end
    tick(H);
    SPI_CS = 1;
    tick(H);
    check("rx_valid_count", rv_cnt - rv0, n);
    check("no_abort", ab_cnt - ab0, 0);
    check("busy_idle", busy, 0);
    check("miso_idle", SPI_MISO, 0);
    check("tx_ready_end", tx_ready, !model_full);
    check("rx_hold", data_received, model_rx);
  endtask
  task automatic abort_frame(input int k);
    int rv0, ab0;
    rv0 = rv_cnt;
    ab0 = ab_cnt;
    model_full = 0;
    SPI_CS = 0;
    tick(H);
    for (int i = 0; i < k; i++) begin
      SPI_MOSI = 1'($urandom);
      tick(H);
      SPI_SCLK = 1;
      tick(H);
      SPI_SCLK = 0;
    end
    tick(H);
    SPI_CS = 1;
    tick(H);
    check("abort_count", ab_cnt - ab0, 1);
    check("abort_no_rx", rv_cnt - rv0, 0);
    check("abort_rx_hold", data_received, model_rx);
    check("abort_busy", busy, 0);
    check("abort_miso", SPI_MISO, 0);
  endtask
  task automatic reset_mid_frame();
    int rv0;
    rv0 = rv_cnt;
    model_full = 0;
    SPI_CS = 0;
    tick(H);
    for (int i = 0; i < 4; i++) begin
      SPI_MOSI = 1'($urandom);
      tick(H);
      SPI_SCLK = 1;
      tick(H);
      SPI_SCLK = 0;
    end
    rst = 1;
    tick(1);
    check("rst_busy", busy, 0);
    check("rst_miso", SPI_MISO, 0);
    check("rst_rx_data", data_received, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_abort", frame_abort, 0);
    check("rst_tx_ready", tx_ready, 1);
    tick(1);
    rst = 0;
    model_rx = 8'd0;
    for (int i = 0; i < 4; i++) begin
      SPI_MOSI = 1'($urandom);
      tick(H);
      check("post_rst_miso", SPI_MISO, 0);
      SPI_SCLK = 1;
      tick(H);
      SPI_SCLK = 0;
      check("post_rst_busy", busy, 0);
    end
    tick(H);
    check("post_rst_no_rx", rv_cnt - rv0, 0);
    SPI_CS = 1;
    tick(H);
  endtask
  initial begin
    tick(3);
    check("init_miso", SPI_MISO, 0);
    check("init_rx_data", data_received, 0);
    check("init_rx_valid", rx_valid, 0);
    check("init_busy", busy, 0);
    check("init_abort", frame_abort, 0);
    check("init_tx_ready", tx_ready, 1);
    rst = 0;
    tick(4);
    load_byte(8'hA5);
    fr_tx[0] = 8'h3C; fr_ld[0] = 0;
    run_frame(1);
    load_byte(8'h81);
    fr_tx[0] = 8'h12; fr_ld[0] = 1; fr_lv[0] = 8'h7E;
    fr_tx[1] = 8'h34; fr_ld[1] = 0;
    run_frame(2);
    fr_tx[0] = 8'h00; fr_ld[0] = 0;
    run_frame(1);
    abort_frame(3);
    fr_tx[0] = 8'h5A; fr_ld[0] = 0;
    run_frame(1);
    reset_mid_frame();
    fr_tx[0] = 8'hC3; fr_ld[0] = 0;
    run_frame(1);
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 3) == 0) abort_frame(int'($urandom_range(1, 7)));
      else begin
        if ($urandom_range(0, 1) == 1) load_byte(8'($urandom));
        if ($urandom_range(0, 2) == 0) load_byte(8'($urandom));
        for (int j = 0; j < 3; j++) begin
          fr_tx[j] = 8'($urandom);
          fr_ld[j] = 1'($urandom);
          fr_lv[j] = 8'($urandom);
        end
        run_frame(int'($urandom_range(1, 3)));
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
